// File: rtl/mont_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier: FSM state encoding
// and the iteration-counter width helper.
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        SUB  = 2'd2,
        FIN  = 2'd3
    } mont_state_t;

    // Counter must be able to hold WIDTH, so a plain $clog2(WIDTH) is one bit short at powers of two.
    function automatic int mont_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/montgomery_param_if.sv
// Request/response bundle between the exponentiation controller (master) and the
// Montgomery multiplier (slave).
interface montgomery_param_if #(
    parameter int WIDTH = 1024
);
    logic             start;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             err;

    modport master (
        output start, in_a, in_b, in_m,
        input  ready, busy, result, done, err
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output ready, busy, result, done, err
    );

endinterface

// File: rtl/mont_iter.sv
// One Montgomery iteration, purely combinational: C' = (C + a*B + q*M) / 2 with q
// chosen to make the sum even. All intermediates are WIDTH+2 bits since C < 2M.
module mont_iter #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH+1:0] i_c,
    input  logic             i_a_bit,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH+1:0] o_c_next
);

    logic [WIDTH+1:0] w_t;
    logic [WIDTH+1:0] w_u;

    assign w_t      = i_c + (i_a_bit ? {2'b00, i_b} : '0);
    assign w_u      = w_t + (w_t[0] ? {2'b00, i_m} : '0);
    assign o_c_next = w_u >> 1;

endmodule

// File: rtl/montgomery_param.sv
// Bit-serial Montgomery multiplier, result = A*B*2^-WIDTH mod M, one iteration per clock.
// Optional operand checking is enabled by defining MONT_OPERAND_CHECK_EN.
module montgomery_param
    import mont_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    montgomery_param_if.slave bus
);

    localparam int CNT_W = mont_cnt_width(WIDTH);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOOP = LOOP;
    localparam logic [1:0] ST_SUB  = SUB;
    localparam logic [1:0] ST_FIN  = FIN;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH+1:0] r_c;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH+1:0] w_c_next;
    logic [WIDTH+1:0] w_diff;

    assign w_accept  = (r_state == ST_IDLE) && bus.start;
    // Shift rather than index: the counter is wider than needed to address r_a.
    assign w_a_shift = r_a >> r_cnt;
    assign w_diff    = r_c - {2'b00, r_m};

    mont_iter #(.WIDTH(WIDTH)) u_iter (
        .i_c      (r_c),
        .i_a_bit  (w_a_shift[0]),
        .i_b      (r_b),
        .i_m      (r_m),
        .o_c_next (w_c_next)
    );

    // NOTE: operand registers are reset along with control so a reset mid-operation leaves no stale state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_c      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_m     <= bus.in_m;
                        r_c     <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    r_c   <= w_c_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= ST_SUB;
                end
                ST_SUB: begin
                    // A set MSB on the difference means C < M: keep C unreduced.
                    r_result <= w_diff[WIDTH+1] ? WIDTH'(r_c) : WIDTH'(w_diff);
                    r_state  <= ST_FIN;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.ready  = (r_state == ST_IDLE);
    assign bus.done   = (r_state == ST_FIN);
    assign bus.result = r_result;

`ifdef MONT_OPERAND_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= !bus.in_m[0] || (bus.in_a >= bus.in_m) || (bus.in_b >= bus.in_m);
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule
